// File: rtl/floating_argmax_pkg.sv
// Shared definitions for the float arg-max stream stage.
// State codes are reused by the other stream stages.
package floating_argmax_pkg;

  localparam int FP32_W = 32;

  localparam logic [FP32_W-1:0] FP_POS_ZERO = 32'h00000000;
  localparam logic [FP32_W-1:0] FP_NEG_ZERO = 32'h80000000;

  localparam logic ACCUM = 1'b0;
  localparam logic DONE  = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/floating_argmax_compare.sv
// FloatingCompare: ge = (a >= b) on IEEE-754 single bit patterns.
// Sign-magnitude order, so +0 ranks above -0.
module floating_argmax_compare
  import floating_argmax_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic              ge
);

  always_comb begin
    ge = 1'b0;
    case ({a[FP32_W-1], b[FP32_W-1]})
      2'b00:   ge = (a[FP32_W-2:0] >= b[FP32_W-2:0]);
      2'b01:   ge = 1'b1;
      2'b10:   ge = 1'b0;
      default: ge = (a[FP32_W-2:0] <= b[FP32_W-2:0]);
    endcase
  end

endmodule

// File: rtl/floating_argmax.sv
// Streaming arg-max over N fp32 beats; result held in DONE
// until the consumer takes it.
module floating_argmax
  import floating_argmax_pkg::*;
#(
  parameter  int N     = 10,
  localparam int IDX_W = idx_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP32_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [FP32_W-1:0] out_value
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic              state;
  logic              state_nxt;
  logic [IDX_W-1:0]  count;
  logic [IDX_W-1:0]  cur_idx;
  logic [FP32_W-1:0] cur_max;
  logic              ge;
  logic              accept;
  logic              last;

  assign accept = in_valid && in_ready;
  assign last   = (count == LAST);

  floating_argmax_compare u_cmp (
    .a  (cur_max),
    .b  (in_data),
    .ge (ge)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last) state_nxt = DONE;
      default: if (out_ready)      state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
  end

  // First beat loads unconditionally; later beats replace only on a strict win.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      cur_idx <= '0;
      cur_max <= '0;
    end else if (accept) begin
      count <= last ? '0 : count + 1'b1;
      if ((count == '0) || !ge) begin
        cur_max <= in_data;
        cur_idx <= count;
      end
    end
  end

  assign out_index = cur_idx;
  assign out_value = cur_max;

endmodule

// File: tb/tb_floating_argmax.sv
// Directed bench for floating_argmax (N=4 and N=2 instances)
// with a queue of expected {index, value} results.
module tb_floating_argmax;
  import floating_argmax_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_index;
  logic [31:0] out_value;

  logic        z_valid;
  logic        z_ready;
  logic [31:0] z_data;
  logic        z_ovalid;
  logic        z_oready;
  logic [0:0]  z_index;
  logic [31:0] z_value;

  int checks = 0;
  int errors = 0;
  logic [35:0] sb[$];

  always #5 clk = ~clk;

  floating_argmax #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_value (out_value)
  );

  floating_argmax #(.N(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (z_valid),
    .in_ready  (z_ready),
    .in_data   (z_data),
    .out_valid (z_ovalid),
    .out_ready (z_oready),
    .out_index (z_index),
    .out_value (z_value)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input int maxgap);
    int g;
    g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    in_valid = 1'b0;
    repeat (g) tick();
    chk("in_ready_accum", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [31:0] a, b, c, d,
                       input logic [1:0] ei, input logic [31:0] ev,
                       input int maxgap);
    sb.push_back({2'b00, ei, ev});
    beat(a, maxgap);
    beat(b, maxgap);
    beat(c, maxgap);
    beat(d, maxgap);
    chk("latency_out_valid", out_valid, 1'b1);
  endtask

  task automatic check_result(input string tag);
    logic [35:0] e;
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    e = sb.pop_front();
    chk({tag, "_index"}, out_index, e[33:32]);
    chk({tag, "_value"}, out_value, e[31:0]);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_out_valid", out_valid, 1'b0);
    chk("drain_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [35:0] ze;
    logic [1:0]  hold_idx;
    logic [31:0] hold_val;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    z_valid = 1'b0;
    z_data = '0;
    z_oready = 1'b0;
    tick();
    tick();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_index", out_index, 2'd0);
    chk("reset_out_value", out_value, 32'h0);
    rst = 1'b0;
    tick();
    chk("reset_in_ready", in_ready, 1'b1);

    send4(32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000,
          2'd1, 32'h40400000, 0);
    check_result("basic");
    drain();

    send4(32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F000000,
          2'd0, 32'h40000000, 0);
    check_result("tie_first");
    drain();

    send4(32'h40000000, 32'h3F800000, 32'h40000000, 32'h40400000,
          2'd3, 32'h40400000, 0);
    check_result("last_wins");
    drain();

    send4(32'hC0000000, 32'hBF800000, 32'hC0400000, 32'hC0000000,
          2'd1, 32'hBF800000, 0);
    check_result("negative");
    drain();

    // Gapped vector, then a held result with a stray beat offered.
    send4(32'h3F800000, 32'h40A00000, 32'h40000000, 32'h3F000000,
          2'd1, 32'h40A00000, 3);
    check_result("gaps");
    hold_idx = 2'd1;
    hold_val = 32'h40A00000;
    in_valid = 1'b1;
    in_data  = 32'h41000000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_index", out_index, hold_idx);
      chk("bp_value", out_value, hold_val);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);
    send4(32'h3F000000, 32'h3F000000, 32'h3F800000, 32'h3F000000,
          2'd2, 32'h3F800000, 2);
    check_result("after_bp");
    drain();

    beat(32'h40400000, 0);
    beat(32'h40000000, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_index", out_index, 2'd0);
    chk("midrst_value", out_value, 32'h0);
    chk("midrst_in_ready", in_ready, 1'b1);
    send4(32'h3F800000, 32'h3F000000, 32'h3F000000, 32'h40000000,
          2'd3, 32'h40000000, 0);
    check_result("post_reset");
    drain();

    // N=2 instance: +0 must beat -0.
    sb.push_back({3'b000, 1'b1, FP_POS_ZERO});
    z_valid = 1'b1;
    z_data  = FP_NEG_ZERO;
    tick();
    chk("z_in_ready", z_ready, 1'b1);
    z_data  = FP_POS_ZERO;
    tick();
    z_valid = 1'b0;
    chk("z_out_valid", z_ovalid, 1'b1);
    ze = sb.pop_front();
    chk("z_index", z_index, ze[32]);
    chk("z_value", z_value, ze[31:0]);
    z_oready = 1'b1;
    tick();
    z_oready = 1'b0;
    chk("z_drain_valid", z_ovalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
